// File: rtl/anc_sched_pkg.sv
// Shared definitions for the anchor TX TDMA scheduler.
//   - sched_state_e : FSM state codes, also exported on the sched_state debug port
//   - DEF_*_LEN     : reset values of the slot and guard lengths
//   - rr_pick       : round-robin search helper, returns {hit, index}
package anc_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WARM = 3'd1,
        ST_SYNC = 3'd2,
        ST_GAP  = 3'd3,
        ST_ARB  = 3'd4,
        ST_TX   = 3'd5
    } sched_state_e;

    localparam int unsigned DEF_SLOT_LEN  = 32768;
    localparam int unsigned DEF_GUARD_LEN = 32768;
    localparam int unsigned RR_MAX_CH     = 16;

    // Walks the channels starting at ptr and wrapping modulo nch; the first
    // eligible channel wins. Works on a 16-wide view so one function serves
    // every channel count from 2 to 16.
    function automatic logic [4:0] rr_pick(input logic [15:0] eligible,
                                           input logic [3:0]  ptr,
                                           input int unsigned nch);
        logic [4:0]  res;
        int unsigned idx;
        res = 5'd0;
        for (int unsigned i = 0; i < RR_MAX_CH; i++) begin
            idx = (32'(ptr) + i) % nch;
            if (i < nch && !res[4] && eligible[idx[3:0]]) begin
                res = {1'b1, idx[3:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/anc_tdma_sched_if.sv
// Configuration channel of the TDMA scheduler.
//   cfg_tvalid    : host offers a new {mask, slot, guard} set
//   cfg_tready    : scheduler can accept it (low while a set is pending)
//   cfg_en_mask   : per-channel enable
//   cfg_slot_len  : TX slot length in cycles
//   cfg_guard_len : guard gap length in cycles
// A transfer happens on a rising clock edge where cfg_tvalid and cfg_tready
// are both high; the fields must be stable while cfg_tvalid is high.
interface anc_tdma_sched_if #(
    parameter int NCH       = 4,
    parameter int CNT_WIDTH = 24
);
    logic                 cfg_tvalid;
    logic                 cfg_tready;
    logic [NCH-1:0]       cfg_en_mask;
    logic [CNT_WIDTH-1:0] cfg_slot_len;
    logic [CNT_WIDTH-1:0] cfg_guard_len;

    modport master (
        output cfg_tvalid, cfg_en_mask, cfg_slot_len, cfg_guard_len,
        input  cfg_tready
    );

    modport slave (
        input  cfg_tvalid, cfg_en_mask, cfg_slot_len, cfg_guard_len,
        output cfg_tready
    );
endinterface

// File: rtl/anc_rr_arbiter.sv
// Combinational round-robin pick. The pointer register lives in the parent.
//   eligible : channels that may be granted this cycle
//   ptr      : channel where the search starts
//   hit      : at least one channel eligible
//   idx      : chosen channel (valid when hit)
module anc_rr_arbiter
    import anc_sched_pkg::*;
#(
    parameter int NCH = 4,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] eligible,
    input  logic [CW-1:0]  ptr,
    output logic           hit,
    output logic [CW-1:0]  idx
);
    logic [4:0] pick;

    always_comb begin
        pick = rr_pick(16'(eligible), 4'(ptr), NCH);
    end

    assign hit = pick[4];
    assign idx = CW'(pick[3:0]);
endmodule

// File: rtl/anc_tdma_sched.sv
// TDMA scheduler for the anchor TX chain. Each frame: DDS warm-up, one
// preamble sync window, then round-robin TX slots among requesting channels,
// with a guard gap (DDS held in soft reset) before every arbitration.
//   clk, reset  : clock, asynchronous active-low reset
//   run         : frames start and continue while high
//   cfg         : config channel (slave side)
//   req         : per-channel TX request, sampled in ARB only
//   sig_done    : signal generator finished its sweep, ends a TX slot early
//   sig_srst    : DDS soft reset, high in GAP
//   prmb_sel    : preamble mux select / GPIO marker, high in SYNC
//   tx_valid    : high in SYNC and TX
//   grant       : one-hot grant, high in TX
//   ch_sel      : granted channel index
//   frame_cnt   : completed frames
//   sched_state : FSM state code
module anc_tdma_sched
    import anc_sched_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CNT_WIDTH  = 24,
    parameter int PRMB_LEN   = 261888,
    parameter int DDS_DELAY  = 32,
    parameter int DEF_SLOT   = DEF_SLOT_LEN,
    parameter int DEF_GUARD  = DEF_GUARD_LEN,
    parameter int FCNT_WIDTH = 16,
    localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    anc_tdma_sched_if.slave       cfg,
    input  logic [NCH-1:0]        req,
    input  logic                  sig_done,
    output logic                  sig_srst,
    output logic                  prmb_sel,
    output logic                  tx_valid,
    output logic [NCH-1:0]        grant,
    output logic [CW-1:0]         ch_sel,
    output logic [FCNT_WIDTH-1:0] frame_cnt,
    output logic [2:0]            sched_state
);
    typedef logic [CNT_WIDTH-1:0] len_t;

    // Zero-length windows would never terminate on a >= (len-1) compare.
    function automatic len_t sanitize(input len_t l);
        return (l == '0) ? len_t'(1) : l;
    endfunction

    sched_state_e          state_q, state_d;
    len_t                  cnt_q, cnt_d;
    logic [NCH-1:0]        served_q, served_d;
    logic [CW-1:0]         ptr_q, ptr_d, ch_q, ch_d;
    logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;
    logic [NCH-1:0]        act_mask_q, act_mask_d, pend_mask_q, pend_mask_d;
    len_t                  act_slot_q, act_slot_d, pend_slot_q, pend_slot_d;
    len_t                  act_guard_q, act_guard_d, pend_guard_q, pend_guard_d;
    logic                  tready_q, tready_d;
    logic                  go_warm;
    logic [NCH-1:0]        eligible;
    logic                  hit;
    logic [CW-1:0]         pick_idx;

    assign eligible = act_mask_q & req & ~served_q;

    anc_rr_arbiter #(.NCH(NCH)) u_arb (
        .eligible (eligible),
        .ptr      (ptr_q),
        .hit      (hit),
        .idx      (pick_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + len_t'(1);
        served_d     = served_q;
        ptr_d        = ptr_q;
        ch_d         = ch_q;
        fcnt_d       = fcnt_q;
        act_mask_d   = act_mask_q;
        act_slot_d   = act_slot_q;
        act_guard_d  = act_guard_q;
        pend_mask_d  = pend_mask_q;
        pend_slot_d  = pend_slot_q;
        pend_guard_d = pend_guard_q;
        tready_d     = tready_q;
        go_warm      = 1'b0;

        // tready low doubles as "pending set waiting for the next frame".
        if (cfg.cfg_tvalid && tready_q) begin
            pend_mask_d  = cfg.cfg_en_mask;
            pend_slot_d  = cfg.cfg_slot_len;
            pend_guard_d = cfg.cfg_guard_len;
            tready_d     = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (run) begin
                    state_d = ST_WARM;
                    go_warm = 1'b1;
                end
            end
            ST_WARM: begin
                if (cnt_q >= len_t'(DDS_DELAY - 1)) begin
                    state_d  = ST_SYNC;
                    cnt_d    = '0;
                    served_d = '0;
                end
            end
            ST_SYNC: begin
                if (cnt_q >= len_t'(PRMB_LEN - 1)) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end
            end
            ST_GAP: begin
                if (cnt_q >= act_guard_q - len_t'(1)) begin
                    state_d = ST_ARB;
                    cnt_d   = '0;
                end
            end
            ST_ARB: begin
                cnt_d = '0;
                if (hit) begin
                    state_d  = ST_TX;
                    ch_d     = pick_idx;
                    served_d = served_q | (NCH'(1) << pick_idx);
                    ptr_d    = (pick_idx == CW'(NCH - 1)) ? '0 : pick_idx + CW'(1);
                end else begin
                    // Nothing left to serve: the frame is complete.
                    fcnt_d = fcnt_q + FCNT_WIDTH'(1);
                    if (run) begin
                        state_d = ST_WARM;
                        go_warm = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_TX: begin
                if (sig_done || cnt_q >= act_slot_q - len_t'(1)) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Config only takes effect at a frame boundary.
        if (go_warm && !tready_q) begin
            act_mask_d  = pend_mask_q;
            act_slot_d  = sanitize(pend_slot_q);
            act_guard_d = sanitize(pend_guard_q);
            tready_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            served_q     <= '0;
            ptr_q        <= '0;
            ch_q         <= '0;
            fcnt_q       <= '0;
            act_mask_q   <= '1;
            act_slot_q   <= sanitize(len_t'(DEF_SLOT));
            act_guard_q  <= sanitize(len_t'(DEF_GUARD));
            pend_mask_q  <= '0;
            pend_slot_q  <= '0;
            pend_guard_q <= '0;
            tready_q     <= 1'b1;
            sig_srst     <= 1'b0;
            prmb_sel     <= 1'b0;
            tx_valid     <= 1'b0;
            grant        <= '0;
        end else begin
            cnt_q        <= cnt_d;
            served_q     <= served_d;
            ptr_q        <= ptr_d;
            ch_q         <= ch_d;
            fcnt_q       <= fcnt_d;
            act_mask_q   <= act_mask_d;
            act_slot_q   <= act_slot_d;
            act_guard_q  <= act_guard_d;
            pend_mask_q  <= pend_mask_d;
            pend_slot_q  <= pend_slot_d;
            pend_guard_q <= pend_guard_d;
            tready_q     <= tready_d;
            // Decoded from the next state so they are valid on state entry.
            sig_srst     <= (state_d == ST_GAP);
            prmb_sel     <= (state_d == ST_SYNC);
            tx_valid     <= (state_d == ST_SYNC) || (state_d == ST_TX);
            grant        <= (state_d == ST_TX) ? (NCH'(1) << ch_d) : '0;
        end
    end

    assign cfg.cfg_tready = tready_q;
    assign ch_sel         = ch_q;
    assign frame_cnt      = fcnt_q;
    assign sched_state    = state_q;
endmodule
